// File: rtl/if_fetch_unit_if.sv
// Bundles the instruction-memory handshake and the IF/ID-facing signals of the fetch stage.
// The master side is the fetch unit; the slave side is the surrounding pipeline and memory.
interface if_fetch_unit_if;
    logic        LE;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ready;
    logic [31:0] Imem_Data;
    logic [31:0] Inst_Out;
    logic [31:0] PC4_Out;
    logic        Inst_Valid;

    modport master (
        input  LE, Branch_Taken, Branch_Target, Imem_Ready, Imem_Data,
        output Imem_Req, Imem_Addr, Inst_Out, PC4_Out, Inst_Valid
    );

    modport slave (
        output LE, Branch_Taken, Branch_Target, Imem_Ready, Imem_Data,
        input  Imem_Req, Imem_Addr, Inst_Out, PC4_Out, Inst_Valid
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, prefetch queue of
// {instruction, PC+4}, stall via LE and branch redirect with drain of an in-flight response.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input logic             CLK,
    input logic             CLR,
    if_fetch_unit_if.master bus
);
    localparam int              PW         = $clog2(QDEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [CW-1:0]   QDEPTH_C   = CW'(QDEPTH);
    localparam logic [31:0]     RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic {FETCH, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   target_q, target_d;
    logic          req_q, req_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   inst_q [QDEPTH];
    logic [31:0]   inst_d [QDEPTH];
    logic [31:0]   pc4_q  [QDEPTH];
    logic [31:0]   pc4_d  [QDEPTH];

    logic [31:0]   pc_plus4;
    logic [31:0]   branch_pc;
    logic          valid;
    logic          push;
    logic          pop;

    assign pc_plus4  = pc_q + 32'd4;
    assign branch_pc = bus.Branch_Target & 32'hFFFF_FFFC;
    assign valid     = (count_q != '0);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        inst_d   = inst_q;
        pc4_d    = pc4_q;
        push     = 1'b0;
        pop      = 1'b0;

        if (bus.Branch_Taken) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            // A request still waiting on memory cannot be retracted, so its response is drained.
            if (req_q && !bus.Imem_Ready) begin
                target_d = branch_pc;
                state_d  = DRAIN;
            end else begin
                pc_d    = branch_pc;
                state_d = FETCH;
            end
        end else if (state_q == DRAIN) begin
            if (bus.Imem_Ready) begin
                pc_d    = target_q;
                state_d = FETCH;
            end
        end else begin
            push = req_q && bus.Imem_Ready;
            pop  = bus.LE && valid;
            if (push) begin
                inst_d[wr_ptr_q] = bus.Imem_Data;
                pc4_d[wr_ptr_q]  = pc_plus4;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                pc_d             = pc_plus4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        // Requests are only issued with a free slot, so the in-flight word always has room.
        req_d = (state_d == DRAIN) || (count_d < QDEPTH_C);
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC_W;
            target_q <= '0;
            req_q    <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                inst_q[i] <= '0;
                pc4_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            req_q    <= req_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            inst_q   <= inst_d;
            pc4_q    <= pc4_d;
        end
    end

    assign bus.Imem_Req   = req_q;
    assign bus.Imem_Addr  = pc_q;
    assign bus.Inst_Valid = valid;
    assign bus.Inst_Out   = valid ? inst_q[rd_ptr_q] : 32'h0;
    assign bus.PC4_Out    = valid ? pc4_q[rd_ptr_q]  : 32'h0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns its own address as the instruction word.
module tb_if_fetch_unit;
    logic clk;
    logic CLR;
    int   vectors;
    int   miscompares;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .CLK (clk),
        .CLR (CLR),
        .bus (bus)
    );

    assign bus.Imem_Data = bus.Imem_Addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic le, input logic rdy);
        CLR               = 1'b0;
        bus.LE            = le;
        bus.Imem_Ready    = rdy;
        bus.Branch_Taken  = 1'b0;
        bus.Branch_Target = 32'h0;
        tick();
        tick();
        CLR = 1'b1;
    endtask

    task automatic test_reset();
        CLR               = 1'b1;
        bus.LE            = 1'b0;
        bus.Imem_Ready    = 1'b0;
        bus.Branch_Taken  = 1'b0;
        bus.Branch_Target = 32'h0;
        #2;
        CLR = 1'b0;
        #1;
        vectors++;
        if (bus.Imem_Req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_req: got %b expected 0", bus.Imem_Req);
        end
        vectors++;
        if (bus.Inst_Valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus.Inst_Valid);
        end
        vectors++;
        if (bus.Inst_Out !== 32'h0 || bus.PC4_Out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outs: got inst %h pc4 %h expected 0/0", bus.Inst_Out, bus.PC4_Out);
        end
        vectors++;
        if (bus.Imem_Addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %h expected 00000000", bus.Imem_Addr);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'(4 * i)) begin
                miscompares++;
                $display("[TB] FAIL stream_addr[%0d]: got req %b addr %h expected 1 %h", i, bus.Imem_Req, bus.Imem_Addr, 32'(4 * i));
            end
            vectors++;
            if (bus.Inst_Valid !== (i != 0)) begin
                miscompares++;
                $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", i, bus.Inst_Valid, (i != 0));
            end
            if (i != 0) begin
                vectors++;
                if (bus.Inst_Out !== 32'(4 * (i - 1)) || bus.PC4_Out !== 32'(4 * i)) begin
                    miscompares++;
                    $display("[TB] FAIL stream_data[%0d]: got %h/%h expected %h/%h", i, bus.Inst_Out, bus.PC4_Out, 32'(4 * (i - 1)), 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_inst [4];
        exp_inst = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (bus.Imem_Req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_req: got %b expected 0", bus.Imem_Req);
        end
        vectors++;
        if (bus.Inst_Valid !== 1'b1 || bus.Inst_Out !== 32'h0 || bus.PC4_Out !== 32'h4) begin
            miscompares++;
            $display("[TB] FAIL stall_head: got %b %h/%h expected 1 00000000/00000004", bus.Inst_Valid, bus.Inst_Out, bus.PC4_Out);
        end
        vectors++;
        if (bus.Imem_Addr !== 32'h8) begin
            miscompares++;
            $display("[TB] FAIL stall_pc: got %h expected 00000008", bus.Imem_Addr);
        end
        bus.LE = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            vectors++;
            if (bus.Inst_Valid !== 1'b1 || bus.Inst_Out !== exp_inst[i] || bus.PC4_Out !== exp_inst[i] + 32'd4) begin
                miscompares++;
                $display("[TB] FAIL stall_release[%0d]: got %b %h/%h expected 1 %h/%h", i, bus.Inst_Valid, bus.Inst_Out, bus.PC4_Out, exp_inst[i], exp_inst[i] + 32'd4);
            end
        end
    endtask

    task automatic test_ready_delay();
        do_reset(1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h0 || bus.Inst_Valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL wait_stable[%0d]: got req %b addr %h valid %b expected 1 00000000 0", i, bus.Imem_Req, bus.Imem_Addr, bus.Inst_Valid);
            end
        end
        bus.Imem_Ready = 1'b1;
        tick();
        bus.Imem_Ready = 1'b0;
        vectors++;
        if (bus.Inst_Valid !== 1'b1 || bus.Inst_Out !== 32'h0 || bus.Imem_Addr !== 32'h4) begin
            miscompares++;
            $display("[TB] FAIL wait_push: got valid %b inst %h addr %h expected 1 00000000 00000004", bus.Inst_Valid, bus.Inst_Out, bus.Imem_Addr);
        end
        tick();
        bus.LE = 1'b1;
        tick();
        vectors++;
        if (bus.Inst_Valid !== 1'b0 || bus.Inst_Out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL wait_single: got valid %b inst %h expected 0 00000000", bus.Inst_Valid, bus.Inst_Out);
        end
    endtask

    task automatic test_branch_drain();
        do_reset(1'b0, 1'b1);
        tick();
        tick();
        bus.Imem_Ready    = 1'b0;
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = 32'h0000_0103;
        tick();
        bus.Branch_Taken = 1'b0;
        bus.LE           = 1'b1;
        vectors++;
        if (bus.Inst_Valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain_flush: got valid %b expected 0", bus.Inst_Valid);
        end
        vectors++;
        if (bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h4) begin
            miscompares++;
            $display("[TB] FAIL drain_hold: got req %b addr %h expected 1 00000004", bus.Imem_Req, bus.Imem_Addr);
        end
        tick();
        bus.Imem_Ready = 1'b1;
        tick();
        vectors++;
        if (bus.Inst_Valid !== 1'b0 || bus.Imem_Addr !== 32'h0000_0100) begin
            miscompares++;
            $display("[TB] FAIL drain_redirect: got valid %b addr %h expected 0 00000100", bus.Inst_Valid, bus.Imem_Addr);
        end
        tick();
        vectors++;
        if (bus.Inst_Valid !== 1'b1 || bus.Inst_Out !== 32'h0000_0100 || bus.PC4_Out !== 32'h0000_0104) begin
            miscompares++;
            $display("[TB] FAIL drain_target: got %b %h/%h expected 1 00000100/00000104", bus.Inst_Valid, bus.Inst_Out, bus.PC4_Out);
        end
    endtask

    task automatic test_branch_ready();
        do_reset(1'b1, 1'b1);
        tick();
        tick();
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = 32'h0000_0200;
        tick();
        bus.Branch_Taken = 1'b0;
        vectors++;
        if (bus.Inst_Valid !== 1'b0 || bus.Imem_Addr !== 32'h0000_0200 || bus.Imem_Req !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL coincide_flush: got valid %b addr %h req %b expected 0 00000200 1", bus.Inst_Valid, bus.Imem_Addr, bus.Imem_Req);
        end
        tick();
        vectors++;
        if (bus.Inst_Valid !== 1'b1 || bus.Inst_Out !== 32'h0000_0200 || bus.PC4_Out !== 32'h0000_0204) begin
            miscompares++;
            $display("[TB] FAIL coincide_target: got %b %h/%h expected 1 00000200/00000204", bus.Inst_Valid, bus.Inst_Out, bus.PC4_Out);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1'b1);
        tick();
        bus.Branch_Taken  = 1'b1;
        bus.Branch_Target = 32'hFFFF_FFFF;
        tick();
        bus.Branch_Taken = 1'b0;
        vectors++;
        if (bus.Imem_Addr !== 32'hFFFF_FFFC || bus.Inst_Valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_target: got addr %h valid %b expected fffffffc 0", bus.Imem_Addr, bus.Inst_Valid);
        end
        tick();
        vectors++;
        if (bus.Inst_Out !== 32'hFFFF_FFFC || bus.PC4_Out !== 32'h0 || bus.Imem_Addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL wrap_pc4: got inst %h pc4 %h addr %h expected fffffffc 00000000 00000000", bus.Inst_Out, bus.PC4_Out, bus.Imem_Addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 1'b1);
        tick();
        tick();
        bus.Imem_Ready = 1'b0;
        tick();
        vectors++;
        if (bus.Imem_Req !== 1'b1 || bus.Inst_Valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_setup: got req %b valid %b expected 1 1", bus.Imem_Req, bus.Inst_Valid);
        end
        #2;
        CLR = 1'b0;
        #1;
        vectors++;
        if (bus.Imem_Req !== 1'b0 || bus.Inst_Valid !== 1'b0 || bus.Inst_Out !== 32'h0 || bus.PC4_Out !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_async: got req %b valid %b %h/%h expected 0 0 0/0", bus.Imem_Req, bus.Inst_Valid, bus.Inst_Out, bus.PC4_Out);
        end
        tick();
        CLR            = 1'b1;
        bus.Imem_Ready = 1'b1;
        tick();
        vectors++;
        if (bus.Imem_Req !== 1'b1 || bus.Imem_Addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_restart: got req %b addr %h expected 1 00000000", bus.Imem_Req, bus.Imem_Addr);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_stream();
        test_stall();
        test_ready_delay();
        test_branch_drain();
        test_branch_ready();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction fetch stage directly upstream of the IF/ID pipeline register. Holds the PC and runs a single-outstanding request/ready handshake to instruction memory. Buffers fetched words with their PC+4 in a small prefetch queue. Presents {instruction, PC+4, valid} to IF/ID, honours the pipeline load-enable (stall), and redirects on taken branches.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.
QDEPTH, 2, prefetch queue entries; power of 2, minimum 2.

Ports:
CLK  in  1  clock, rising edge.
CLR  in  1  reset, asynchronous, active-low.
LE  in  1  IF/ID load enable; 1 = consumer takes Inst_Out this cycle, 0 = stall.
Branch_Taken  in  1  redirect request, one-cycle pulse from EX.
Branch_Target  in  32  redirect address; bits [1:0] ignored and forced 0.
Imem_Req  out  1  memory request valid.
Imem_Addr  out  32  word address of the request.
Imem_Ready  in  1  memory returns Imem_Data this cycle.
Imem_Data  in  32  fetched instruction word.
Inst_Out  out  32  queue head instruction (feeds IFID_In).
PC4_Out  out  32  queue head PC+4 (feeds PC4_In).
Inst_Valid  out  1  queue non-empty.

Behaviour:
- Reset (CLR=0, async): PC=RESET_PC, queue empty, FSM=FETCH, Imem_Req=0, Inst_Out=0, PC4_Out=0, Inst_Valid=0.
- FSM states: FETCH (normal), DRAIN (discard one in-flight response after redirect).
- Request rule: Imem_Req=1 in FETCH when free slots > 0 (free = QDEPTH - count, counting the in-flight word). Imem_Addr=PC.
- Once asserted, Imem_Req and Imem_Addr stay stable until a cycle with Imem_Ready=1 (no retraction, even across a branch).
- Response in FETCH: at a posedge with Imem_Req & Imem_Ready, push {Imem_Data, PC+4} into the queue. PC<=PC+4, 32-bit wrap (32'hFFFFFFFC -> 0).
- Minimum latency: Ready in cycle N -> Inst_Valid=1 in cycle N+1. Back-to-back requests are allowed; Req may stay high across Ready.
- Pop: at a posedge with LE=1 & Inst_Valid=1, the head is removed. Push and pop in the same cycle leave count unchanged, and that push is allowed even with the queue full.
- Inst_Out/PC4_Out read the head storage directly (registered, no combinational path from Imem_Data). When empty they are 0 with Inst_Valid=0.
- Branch_Taken=1 at a posedge (priority over push/pop):
  - Flush the queue (count=0).
  - If a request is outstanding without Ready this cycle: latch target, go to DRAIN.
  - Otherwise: PC<=target and stay in FETCH.
  - A Ready in the same cycle as the branch is discarded.
- DRAIN: Imem_Req stays 1 with the old address. On Imem_Ready, discard the data, PC<=latched target, go to FETCH. A further branch during DRAIN overwrites the latched target.
- LE=0 with a full queue: Imem_Req stays 0. An outstanding request completes into its reserved slot.
- Reset asserted mid-transaction drops the request immediately. Memory must tolerate this.

Test Plan:
- Reset release, Imem_Ready tied 1, data=addr: Imem_Addr sequence 0,4,8,…; Inst_Valid high from 2nd cycle; Inst_Out=0,4,8 with PC4_Out=4,8,12 under LE=1.
- LE=0 held 6 cycles, Ready=1: exactly QDEPTH=2 words buffered, Imem_Req low thereafter. LE=1 then releases the words in order, no loss or duplication.
- Ready delayed 3 cycles: Imem_Req/Imem_Addr stable for all 3 wait cycles; exactly one push.
- Branch_Taken to 32'h00000103 with a request outstanding, Ready 2 cycles later: queue flushed, drained word never appears, next Imem_Addr=32'h00000100, Inst_Out then shows the target word with PC4_Out=32'h00000104.
- Branch coincident with Ready and LE=1: returned word discarded, no pop of stale data, next fetch at target.
- CLR asserted while Imem_Req=1 mid-wait: outputs go to reset values immediately (async); after release, first Imem_Addr=RESET_PC.
